// File: rtl/lfsr_pkg.sv
// Shared PRBS link types: injection modes, checker states, LFSR step function.
// Pure declarations, no timing or flow control.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    INJ_NONE     = 2'b00,
    INJ_SINGLE   = 2'b01,
    INJ_CONT     = 2'b10,
    INJ_PERIODIC = 2'b11
  } inj_mode_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } chk_state_t;

  // Callers zero-extend into LFSR_MAX_W and truncate the result back to WIDTH.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load; one step per cycle while i_valid is high.
// Soft reload wins over advance; an all-zero seed is replaced by all-ones.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_soft_reset,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] next_state;

  assign next_state = WIDTH'(lfsr_next(LFSR_MAX_W'(o_state), LFSR_MAX_W'(TAPS)));

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      o_state <= WIDTH'(1);
    end else if (i_soft_reset) begin
      o_state <= (i_seed == '0) ? '1 : i_seed;
    end else if (i_valid) begin
      o_state <= next_state;
    end
  end

endmodule

// File: rtl/lfsr_prbs_link.sv
// PRBS link test: generator, bit-0 error injection and self-synchronising checker.
// Checker verdicts and lock appear one cycle after the word; no backpressure, i_valid gates all progress.
module lfsr_prbs_link
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter int               LOCK_CNT   = 4,
  parameter int               UNLOCK_CNT = 3,
  parameter int               ERR_W      = 16,
  parameter int               INJ_PERIOD = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_soft_reset,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [1:0]       i_inj_mode,
  input  logic             i_inj_trig,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_lfsr,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int LK_W  = $clog2(LOCK_CNT + 1);
  localparam int UL_W  = $clog2(UNLOCK_CNT + 1);
  localparam int PER_W = $clog2(INJ_PERIOD);

  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_next;
  logic             has_prev;
  logic             inject;
  logic             mode_chg;
  logic             match;
  logic             mism;
  inj_mode_t        mode_q;
  chk_state_t       state_q;
  logic             inj_armed;
  logic [PER_W-1:0] per_cnt;
  logic [LK_W-1:0]  match_run;
  logic [UL_W-1:0]  mism_run;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_soft_reset (i_soft_reset),
    .i_seed       (i_seed),
    .o_state      (o_lfsr)
  );

  // A mode switch restarts single-shot and periodic bookkeeping from scratch.
  assign mode_chg = (i_inj_mode != mode_q);

  always_comb begin
    inject = 1'b0;
    case (inj_mode_t'(i_inj_mode))
      INJ_CONT:     inject = i_valid;
      INJ_SINGLE:   inject = i_valid && inj_armed && !mode_chg;
      INJ_PERIODIC: inject = i_valid && !mode_chg && (per_cnt == PER_W'(INJ_PERIOD - 1));
      default:      inject = 1'b0;
    endcase
  end

  assign tx        = inject ? (o_lfsr ^ WIDTH'(1)) : o_lfsr;
  assign prev_next = WIDTH'(lfsr_next(LFSR_MAX_W'(prev), LFSR_MAX_W'(TAPS)));
  assign match     = i_valid && has_prev && (tx == prev_next);
  assign mism      = i_valid && has_prev && (tx != prev_next);

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q    <= INJ_NONE;
      inj_armed <= 1'b0;
      per_cnt   <= '0;
    end else begin
      mode_q <= inj_mode_t'(i_inj_mode);
      if (mode_chg) begin
        inj_armed <= 1'b0;
        per_cnt   <= '0;
      end else begin
        if (inj_mode_t'(i_inj_mode) == INJ_SINGLE && i_inj_trig) begin
          inj_armed <= 1'b1;
        end else if (inject) begin
          inj_armed <= 1'b0;
        end
        if (inj_mode_t'(i_inj_mode) == INJ_PERIODIC && i_valid) begin
          per_cnt <= (per_cnt == PER_W'(INJ_PERIOD - 1)) ? '0 : per_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      prev      <= '0;
      has_prev  <= 1'b0;
      state_q   <= ST_UNLOCKED;
      match_run <= '0;
      mism_run  <= '0;
      o_lock    <= 1'b0;
    end else if (i_valid) begin
      prev     <= tx;
      has_prev <= 1'b1;
      case (state_q)
        ST_UNLOCKED: begin
          if (mism) begin
            match_run <= '0;
          end else if (match) begin
            if (match_run == LK_W'(LOCK_CNT - 1)) begin
              state_q   <= ST_LOCKED;
              o_lock    <= 1'b1;
              match_run <= '0;
              mism_run  <= '0;
            end else begin
              match_run <= match_run + 1'b1;
            end
          end
        end
        default: begin
          if (match) begin
            mism_run <= '0;
          end else if (mism) begin
            if (mism_run == UL_W'(UNLOCK_CNT - 1)) begin
              state_q   <= ST_UNLOCKED;
              o_lock    <= 1'b0;
              match_run <= '0;
              mism_run  <= '0;
            end else begin
              mism_run <= mism_run + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      o_err_cnt <= '0;
    end else if (i_err_clr) begin
      o_err_cnt <= '0;
    end else if (mism && state_q == ST_LOCKED && o_err_cnt != '1) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_link.sv
// Directed bench for lfsr_prbs_link; a second instance with a 2-bit error counter
// shares all inputs to exercise saturation.
module tb_lfsr_prbs_link;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       i_soft_reset;
  logic [7:0] i_seed;
  logic [1:0] i_inj_mode;
  logic       i_inj_trig;
  logic       i_err_clr;
  logic [7:0] o_lfsr;
  logic       o_lock;
  logic [15:0] o_err_cnt;
  logic [7:0] s_lfsr;
  logic       s_lock;
  logic [1:0] s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_prbs_link dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_soft_reset (i_soft_reset),
    .i_seed       (i_seed),
    .i_inj_mode   (i_inj_mode),
    .i_inj_trig   (i_inj_trig),
    .i_err_clr    (i_err_clr),
    .o_lfsr       (o_lfsr),
    .o_lock       (o_lock),
    .o_err_cnt    (o_err_cnt)
  );

  lfsr_prbs_link #(.ERR_W(2)) dut_sat (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_soft_reset (i_soft_reset),
    .i_seed       (i_seed),
    .i_inj_mode   (i_inj_mode),
    .i_inj_trig   (i_inj_trig),
    .i_err_clr    (i_err_clr),
    .o_lfsr       (s_lfsr),
    .o_lock       (s_lock),
    .o_err_cnt    (s_err_cnt)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    i_rst        = 1'b0;
    i_valid      = 1'b0;
    i_soft_reset = 1'b0;
    i_seed       = 8'h01;
    i_inj_mode   = 2'b00;
    i_inj_trig   = 1'b0;
    i_err_clr    = 1'b0;
    cyc();
    cyc();
    i_rst = 1'b1;
    cyc();
  endtask

  task automatic run_words(input int n);
    i_valid = 1'b1;
    repeat (n) cyc();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (o_lfsr !== 8'h01) begin errors++; $display("FAIL reset_lfsr got %h want 01", o_lfsr); end
    checks++;
    if (o_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", o_lock); end
    checks++;
    if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_seed_sequence();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    apply_reset();
    i_seed = 8'h01;
    i_soft_reset = 1'b1;
    cyc();
    i_soft_reset = 1'b0;
    checks++;
    if (o_lfsr !== 8'h01) begin errors++; $display("FAIL seed_load got %h want 01", o_lfsr); end
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (o_lfsr !== exp_seq[k]) begin
        errors++; $display("FAIL seq_word%0d got %h want %h", k, o_lfsr, exp_seq[k]);
      end
      checks++;
      if (o_lock !== (k == 4)) begin
        errors++; $display("FAIL seq_lock%0d got %b want %b", k, o_lock, (k == 4));
      end
    end
    i_valid = 1'b0;
    checks++;
    if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL seq_err got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_zero_seed();
    apply_reset();
    i_seed = 8'h00;
    i_soft_reset = 1'b1;
    i_valid = 1'b1;
    cyc();
    i_soft_reset = 1'b0;
    checks++;
    if (o_lfsr !== 8'hFF) begin errors++; $display("FAIL zero_seed got %h want ff", o_lfsr); end
    cyc();
    i_valid = 1'b0;
    checks++;
    if (o_lfsr !== 8'hFE) begin errors++; $display("FAIL zero_seed_next got %h want fe", o_lfsr); end
  endtask

  task automatic test_single_shot();
    apply_reset();
    run_words(5);
    i_inj_mode = 2'b01;
    cyc();
    i_inj_trig = 1'b1;
    cyc();
    i_inj_trig = 1'b0;
    run_words(4);
    checks++;
    if (o_err_cnt !== 16'd2) begin errors++; $display("FAIL single_err1 got %0d want 2", o_err_cnt); end
    checks++;
    if (o_lock !== 1'b1) begin errors++; $display("FAIL single_lock got %b want 1", o_lock); end
    i_inj_trig = 1'b1;
    cyc();
    i_inj_trig = 1'b0;
    run_words(4);
    checks++;
    if (o_err_cnt !== 16'd4) begin errors++; $display("FAIL single_err2 got %0d want 4", o_err_cnt); end
    checks++;
    if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL sat_err got %0d want 3", s_err_cnt); end
    run_words(6);
    checks++;
    if (o_err_cnt !== 16'd4) begin errors++; $display("FAIL single_no_rearm got %0d want 4", o_err_cnt); end
    i_err_clr = 1'b1;
    cyc();
    i_err_clr = 1'b0;
    checks++;
    if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL clr_err got %0d want 0", o_err_cnt); end
    checks++;
    if (s_err_cnt !== 2'd0) begin errors++; $display("FAIL clr_sat got %0d want 0", s_err_cnt); end
  endtask

  task automatic test_continuous();
    apply_reset();
    run_words(5);
    i_inj_mode = 2'b10;
    i_valid = 1'b1;
    cyc();
    cyc();
    checks++;
    if (o_lock !== 1'b1) begin errors++; $display("FAIL cont_lock2 got %b want 1", o_lock); end
    cyc();
    checks++;
    if (o_lock !== 1'b0) begin errors++; $display("FAIL cont_unlock got %b want 0", o_lock); end
    checks++;
    if (o_err_cnt !== 16'd3) begin errors++; $display("FAIL cont_err got %0d want 3", o_err_cnt); end
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (o_lock !== 1'b0) begin errors++; $display("FAIL cont_relock%0d got %b want 0", k, o_lock); end
    end
    i_valid = 1'b0;
    checks++;
    if (o_err_cnt !== 16'd3) begin errors++; $display("FAIL cont_err_hold got %0d want 3", o_err_cnt); end
    i_inj_mode = 2'b00;
    cyc();
  endtask

  task automatic test_periodic();
    int bad_lock;
    bad_lock = 0;
    apply_reset();
    run_words(5);
    i_inj_mode = 2'b11;
    cyc();
    i_valid = 1'b1;
    for (int k = 0; k < 165; k++) begin
      cyc();
      if (o_lock !== 1'b1) bad_lock++;
    end
    i_valid = 1'b0;
    checks++;
    if (bad_lock != 0) begin errors++; $display("FAIL per_lock dropped %0d cycles want 0", bad_lock); end
    checks++;
    if (o_err_cnt !== 16'd20) begin errors++; $display("FAIL per_err got %0d want 20", o_err_cnt); end
    checks++;
    if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL per_sat got %0d want 3", s_err_cnt); end
  endtask

  task automatic test_async_reset();
    i_inj_mode = 2'b10;
    i_valid = 1'b1;
    cyc();
    cyc();
    #2;
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_lfsr !== 8'h01) begin errors++; $display("FAIL arst_lfsr got %h want 01", o_lfsr); end
    checks++;
    if (o_lock !== 1'b0) begin errors++; $display("FAIL arst_lock got %b want 0", o_lock); end
    checks++;
    if (o_err_cnt !== 16'd0) begin errors++; $display("FAIL arst_err got %0d want 0", o_err_cnt); end
    i_valid = 1'b0;
    i_inj_mode = 2'b00;
    @(negedge clk);
    i_rst = 1'b1;
    cyc();
    run_words(4);
    checks++;
    if (o_lock !== 1'b0) begin errors++; $display("FAIL relock4 got %b want 0", o_lock); end
    run_words(1);
    checks++;
    if (o_lock !== 1'b1) begin errors++; $display("FAIL relock5 got %b want 1", o_lock); end
  endtask

  initial begin
    i_rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_seed_sequence();
    test_zero_seed();
    test_single_shot();
    test_continuous();
    test_periodic();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_link.md
Name: lfsr_prbs_link

Overview:
- Parametrised PRBS link-test block: an LFSR pattern generator, an error-injection stage and a self-synchronising checker, all in one clock domain.
- Successor to the fixed 8-bit generator/checker pair. Adds:
  - generic width and taps
  - lock/unlock hysteresis
  - a saturating error counter
  - selectable injection modes (single-shot, continuous, periodic)
- Drives board LEDs and debug registers in bring-up builds.

Parameters:
- WIDTH, 8: LFSR/data width, >= 3.
- TAPS, 8'hB8: feedback mask, WIDTH bits. Feedback = XOR-reduce(state & TAPS).
- LOCK_CNT, 4: consecutive matches required to declare lock, >= 1.
- UNLOCK_CNT, 3: consecutive mismatches while locked to drop lock, >= 1.
- ERR_W, 16: error counter width.
- INJ_PERIOD, 16: valid words between injections in periodic mode, >= 2.

Ports:
- clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-low reset (0 = reset)
- i_valid  in  1  advance enable; one word per cycle while high
- i_soft_reset  in  1  synchronous reload of i_seed into the generator
- i_seed  in  WIDTH  generator seed
- i_inj_mode  in  2  00 none, 01 single-shot, 10 continuous, 11 periodic
- i_inj_trig  in  1  arms one injection in single-shot mode (level sampled per cycle)
- i_err_clr  in  1  synchronous clear of the error counter
- o_lfsr  out  WIDTH  generator state, before injection
- o_lock  out  1  checker locked
- o_err_cnt  out  ERR_W  saturating mismatch count while locked

Behaviour:
- Reset (i_rst=0, async) values:
  - generator state = 1 (LSB set)
  - o_lock = 0, o_err_cnt = 0
  - checker FSM = UNLOCKED, match/mismatch run counters = 0
  - has_prev = 0, inj_armed = 0, period counter = 0
- Zero-seed rule: a seed of all zeros is replaced by all-ones, both at soft reset and on every load.
- Generator:
  - Fibonacci form: next = {state[WIDTH-2:0], ^(state & TAPS)}.
  - i_soft_reset has priority over i_valid: state <= i_seed (zero-seed rule applies). No advance that cycle.
  - Otherwise, if i_valid: state <= next. o_lfsr is the registered state.
- Injection: tx = o_lfsr with bit 0 inverted when inject is true, otherwise tx = o_lfsr. tx is combinational into the checker. Per mode:
  - 00: never inject.
  - 10: inject on every valid cycle.
  - 01: i_inj_trig sets inj_armed. The first valid cycle with inj_armed=1 injects and clears inj_armed. Trig and consume in the same cycle leaves inj_armed=1.
  - 11: period counter counts valid cycles 0..INJ_PERIOD-1 and wraps; inject when counter == INJ_PERIOD-1.
  - A mode change resets the period counter and clears inj_armed.
- Checker, evaluated only on i_valid cycles:
  - prev <= tx and has_prev <= 1 on each valid cycle.
  - match = has_prev && (tx == next(prev)). The first word after reset is neither match nor mismatch.
  - Checker state is not affected by i_soft_reset; the sequence discontinuity is a mismatch.
- FSM, 2 states:
  - UNLOCKED: each match increments the match run; a mismatch zeroes it. Reaching LOCK_CNT goes to LOCKED and zeroes both runs.
  - LOCKED: each mismatch increments the mismatch run; a match zeroes it. Reaching UNLOCK_CNT goes to UNLOCKED and zeroes both runs.
  - o_lock is registered and reflects the state from the cycle after the deciding word.
- Error counter:
  - Increments by 1 on each mismatch evaluated in LOCKED, including the one that unlocks.
  - Saturates at 2^ERR_W-1.
  - i_err_clr has priority over an increment in the same cycle.
- One injected bit flip corrupts two checker comparisons (bad word, then the good word compared against the bad prev). Expect 2 mismatches per single injection.

Decomposition:
- Package lfsr_pkg:
  - injection mode constants INJ_NONE / INJ_SINGLE / INJ_CONT / INJ_PERIODIC
  - checker state encoding ST_UNLOCKED / ST_LOCKED
  - function lfsr_next(state, taps)
- Sub-module lfsr_core (WIDTH, TAPS): state register, seed load, zero-seed rule.
- Checker FSM, injection logic and counters live in lfsr_prbs_link.

Test Plan:
- Seed/sequence: defaults, i_seed=0x01, soft reset, then valid held -> o_lfsr 0x01,0x02,0x04,0x08,0x11; o_lock=1 one cycle after the 5th valid word (4 matches); o_err_cnt=0.
- Zero seed: i_seed=0x00 plus soft reset -> o_lfsr=0xFF; the next valid gives 0xFE.
- Single-shot: locked, mode 01, pulse i_inj_trig -> o_err_cnt=2, o_lock stays 1; trig again -> 4; i_err_clr -> 0.
- Continuous: locked, mode 10 -> o_lock falls the cycle after the 3rd mismatch word; o_err_cnt=3; it never relocks while mode 10 is held.
- Periodic: mode 11, INJ_PERIOD=16, 160 locked words -> o_err_cnt=20, o_lock=1 throughout.
- Saturation/reset: ERR_W=2, continuous injection -> o_err_cnt saturates at 3. Async i_rst low mid-stream -> all outputs at reset values immediately; relock takes 5 valid words.
